// File: rtl/led_serial_rx.sv
// ----------------------------------------------------------------------------
// led_serial_rx : receive end of the 4-wire serial LED link (sync, shift, latch)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module led_serial_rx #(
  parameter int WIDTH       = 16,
  parameter bit MSB_FIRST   = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          led_clk,
  input  logic                          led_do,
  input  logic                          led_clr,
  input  logic                          led_pen,
  output logic [WIDTH-1:0]              data,
  output logic                          data_valid,
  output logic                          frame_err,
  output logic                          busy,
  output logic [$clog2(WIDTH+2)-1:0]    bit_count
);

  localparam int                CW          = $clog2(WIDTH+2);
  localparam logic [CW-1:0]     C_CNT_MAX   = CW'(WIDTH + 1);
  localparam logic [CW-1:0]     C_CNT_FULL  = CW'(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_do_sync;
  logic [SYNC_STAGES-1:0] r_clr_sync;
  logic [SYNC_STAGES-1:0] r_pen_sync;
  logic                   r_clk_hist;
  logic                   r_pen_hist;
  logic [WIDTH-1:0]       r_sr;
  logic [WIDTH-1:0]       w_sr_shifted;
  logic                   w_shift;
  logic                   w_clear;
  logic                   w_latch;
  logic                   w_do_s;

  // led_clr idles high, so its synchroniser presets to 1 to avoid a spurious clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync <= '0;
      r_do_sync  <= '0;
      r_clr_sync <= '1;
      r_pen_sync <= '0;
      r_clk_hist <= 1'b0;
      r_pen_hist <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], led_clk};
      r_do_sync  <= {r_do_sync[SYNC_STAGES-2:0],  led_do};
      r_clr_sync <= {r_clr_sync[SYNC_STAGES-2:0], led_clr};
      r_pen_sync <= {r_pen_sync[SYNC_STAGES-2:0], led_pen};
      r_clk_hist <= r_clk_sync[SYNC_STAGES-1];
      r_pen_hist <= r_pen_sync[SYNC_STAGES-1];
    end
  end

  assign w_do_s  = r_do_sync[SYNC_STAGES-1];
  assign w_shift = r_clk_sync[SYNC_STAGES-1] & ~r_clk_hist;
  assign w_latch = r_pen_sync[SYNC_STAGES-1] & ~r_pen_hist;
  assign w_clear = ~r_clr_sync[SYNC_STAGES-1];

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sr_shifted = {r_sr[WIDTH-2:0], w_do_s};
    end else begin : g_lsb_first
      assign w_sr_shifted = {w_do_s, r_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A latch coinciding with a shift keeps the new bit, so the next frame is already underway
  always_comb begin
    w_state_next = r_state;
    busy         = (r_state == S_SHIFT);
    if (w_clear) begin
      w_state_next = S_IDLE;
    end else if (w_latch) begin
      w_state_next = w_shift ? S_SHIFT : S_IDLE;
    end else if (w_shift) begin
      w_state_next = S_SHIFT;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sr       <= '0;
      bit_count  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= w_latch;
      if (w_latch) begin
        data      <= r_sr;
        frame_err <= (bit_count != C_CNT_FULL);
      end

      if (w_clear) begin
        r_sr      <= '0;
        bit_count <= '0;
      end else begin
        if (w_shift) begin
          r_sr <= w_sr_shifted;
        end
        if (w_latch) begin
          bit_count <= w_shift ? CW'(1) : '0;
        end else if (w_shift && (bit_count != C_CNT_MAX)) begin
          bit_count <= bit_count + CW'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire
